mips32_prog_loader: RTL and testbench

//  Boot-time program loader upstream of pipe_MIPS32. Receives a byte stream (header + big-endian

---
 rtl/mips32_prog_loader.sv | 139 +++++++++++++
 tb/tb_mips32_prog_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader: takes a header + big-endian word stream over valid/ready,
// writes it into processor memory, then releases the CPU at the loaded base PC.
module mips32_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] pc_init,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  // Stream handshake: a byte moves on a rising edge where s_valid && s_ready; with
  // s_ready low the byte stays pending upstream and s_data must be held stable.
  typedef enum logic [1:0] {HDR, LOAD, DONE, ERR} state_t;

  localparam logic [16:0] MEM_WORDS = 17'(1 << ADDR_W);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;

  logic        xfer;
  logic [15:0] hdr_cnt;
  logic [15:0] hdr_base;
  logic [16:0] hdr_end;
  logic        base_hi_bad;
  logic        last_word;

  always_comb begin
    xfer        = s_valid & s_ready;
    hdr_cnt     = shreg[23:8];
    hdr_base    = {shreg[7:0], s_data};
    hdr_end     = {1'b0, hdr_cnt} + {1'b0, hdr_base};
    base_hi_bad = (hdr_base >> ADDR_W) != 16'd0;
    last_word   = 16'(idx) == (cnt - 16'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR;
      byte_cnt  <= 2'd0;
      shreg     <= 24'd0;
      cnt       <= 16'd0;
      base      <= '0;
      idx       <= '0;
      s_ready   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      pc_init   <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (xfer) begin
            shreg    <= {shreg[15:0], s_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              cnt  <= hdr_cnt;
              base <= hdr_base[ADDR_W-1:0];
              idx  <= '0;
              // A base outside memory is rejected even for an empty program.
              if (base_hi_bad || (hdr_cnt != 16'd0 && hdr_end > MEM_WORDS)) begin
                state   <= ERR;
                s_ready <= 1'b0;
                err     <= 1'b1;
              end else if (hdr_cnt == 16'd0) begin
                state   <= DONE;
                s_ready <= 1'b0;
                done    <= 1'b1;
                pc_init <= hdr_base[ADDR_W-1:0];
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            shreg    <= {shreg[15:0], s_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= base + idx;
              mem_wdata <= {shreg, s_data};
              idx       <= idx + ADDR_W'(1);
              if (last_word) begin
                state   <= DONE;
                s_ready <= 1'b0;
                done    <= 1'b1;
                pc_init <= base;
              end
            end
          end
        end
        DONE: begin
          if (reload) begin
            state     <= HDR;
            s_ready   <= 1'b1;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
            byte_cnt  <= 2'd0;
            idx       <= '0;
            cnt       <= 16'd0;
          end else begin
            cpu_rst_n <= 1'b1;
          end
        end
        ERR: begin
          if (reload) begin
            state    <= HDR;
            s_ready  <= 1'b1;
            err      <= 1'b0;
            byte_cnt <= 2'd0;
            idx      <= '0;
            cnt      <= 16'd0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: table of load scenarios, a write-queue reference model
// built from the stream format, and hand sequences for reload and mid-load reset.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] pc_init;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_init(pc_init), .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          base;
    bit          fact;
    bit          use_w0;
    logic [31:0] w0;
    int          gap;
    bit          exp_err;
    int          exp_pc;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] fact_prog[11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                                 32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                                 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
  logic [31:0] words[$];
  logic [41:0] exp_q[$];
  logic [41:0] mon_e;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int cnt, input int base, input bit fact, input bit use_w0,
                              input logic [31:0] w0, input int gap, input bit exp_err,
                              input int exp_pc);
    vec_t v;
    v.cnt = cnt; v.base = base; v.fact = fact; v.use_w0 = use_w0; v.w0 = w0;
    v.gap = gap; v.exp_err = exp_err; v.exp_pc = exp_pc;
    return v;
  endfunction

  // Reference model: a load is legal when it fits in memory; each word i lands at base+i.
  function automatic void model_push(input int cnt, input int base);
    if (base < MEM_WORDS && base + cnt <= MEM_WORDS)
      for (int i = 0; i < cnt; i++)
        exp_q.push_back({10'(base + i), words[i]});
  endfunction

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e[41:32]));
        chk("wr_data", mem_wdata, mon_e[31:0]);
      end
    end
  end

  // Called and returns at a falling edge; the byte transfers on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got s_ready 0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_header(input int cnt, input int base, input int gap);
    send_byte(8'(cnt >> 8), gap);
    send_byte(8'(cnt), gap);
    send_byte(8'(base >> 8), gap);
    send_byte(8'(base), gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("reload_done", 32'(done), 0);
    chk("reload_err", 32'(err), 0);
    chk("reload_s_ready", 32'(s_ready), 1);
  endtask

  task automatic run_vec(input vec_t v);
    words.delete();
    for (int i = 0; i < v.cnt; i++)
      words.push_back(v.fact ? fact_prog[i] : ((i == 0 && v.use_w0) ? v.w0 : $urandom));
    model_push(v.cnt, v.base);
    send_header(v.cnt, v.base, v.gap);
    if (v.exp_err) begin
      chk("err_flag", 32'(err), 1);
      chk("err_s_ready", 32'(s_ready), 0);
      chk("err_done", 32'(done), 0);
      repeat (5) @(negedge clk);
      chk("err_cpu_rst_hold", 32'(cpu_rst_n), 0);
      chk("err_s_ready_hold", 32'(s_ready), 0);
    end else begin
      for (int i = 0; i < v.cnt; i++) send_word(words[i], v.gap);
      chk("cpu_rst_before_release", 32'(cpu_rst_n), 0);
      @(negedge clk);
      chk("release_cpu_rst_n", 32'(cpu_rst_n), 1);
      chk("done_flag", 32'(done), 1);
      chk("pc_init", 32'(pc_init), 32'(v.exp_pc));
      chk("done_s_ready", 32'(s_ready), 0);
      chk("done_err", 32'(err), 0);
    end
    chk("writes_pending", 32'(exp_q.size()), 0);
    pulse_reload();
  endtask

  initial begin
    vecs[0] = mk(11, 0,       1'b1, 1'b0, 32'h0,        0, 1'b0, 0);
    vecs[1] = mk(1,  200,     1'b0, 1'b1, 32'h00000007, 0, 1'b0, 200);
    vecs[2] = mk(0,  5,       1'b0, 1'b0, 32'h0,        0, 1'b0, 5);
    vecs[3] = mk(2,  1023,    1'b0, 1'b0, 32'h0,        0, 1'b1, 0);
    vecs[4] = mk(3,  100,     1'b0, 1'b0, 32'h0,        3, 1'b0, 100);
    vecs[5] = mk(1,  1023,    1'b0, 1'b0, 32'h0,        1, 1'b0, 1023);
    vecs[6] = mk(4,  1021,    1'b0, 1'b0, 32'h0,        0, 1'b1, 0);
    vecs[7] = mk(1,  16'h400, 1'b0, 1'b0, 32'h0,        0, 1'b1, 0);
    vecs[8] = mk(1,  16,      1'b0, 1'b0, 32'h0,        2, 1'b0, 16);

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pc_init", 32'(pc_init), 0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 9; n++) run_vec(vecs[n]);

    // Gapped load of 3 words, reset asserted partway through word 2.
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    model_push(2, 40);
    send_header(3, 40, 2);
    send_word(words[0], 2);
    send_word(words[1], 2);
    send_byte(words[2][31:24], 2);
    send_byte(words[2][23:16], 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_mem_we", 32'(mem_we), 0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 1);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_cpu_rst_hold", 32'(cpu_rst_n), 0);
    chk("midrst_writes_pending", 32'(exp_q.size()), 0);

    // Header alignment must restart cleanly after the abandoned load.
    run_vec(mk(2, 50, 1'b0, 1'b0, 32'h0, 1, 1'b0, 50));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
